// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file, imported by the
// regfile, the core and the decode stage.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/write-back facing bus of the multi-port register file.
// master = pipeline side, slave = register file.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0][AW-1:0]   rs_num;
  logic [NRD-1:0][XLEN-1:0] rs_data;
  logic [NRD-1:0]           rs_busy;
  logic [NWR-1:0][AW-1:0]   rd_num;
  logic [NWR-1:0][XLEN-1:0] rd_data;
  logic [NWR-1:0]           rd_we;
  logic                     resv_valid;
  logic [AW-1:0]            resv_num;
  logic [AW:0]              pending_cnt;
  logic                     sb_err;
  logic                     halted;

  modport master (
    output rs_num, rd_num, rd_data, rd_we, resv_valid, resv_num, halted,
    input  rs_data, rs_busy, pending_cnt, sb_err
  );

  modport slave (
    input  rs_num, rd_num, rd_data, rd_we, resv_valid, resv_num, halted,
    output rs_data, rs_busy, pending_cnt, sb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register with an in-flight producer.
// Reservations win over same-cycle releases; reserving a register that is
// still busy sets a sticky error flag.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    halted,
  input  logic [NREG-1:0]         clr,
  input  logic                    resv_valid,
  input  logic [$clog2(NREG)-1:0] resv_num,
  output logic [NREG-1:0]         busy,
  output logic [$clog2(NREG):0]   pending_cnt,
  output logic                    sb_err
);
  localparam int AW = $clog2(NREG);
  localparam int CW = AW + 1;

  logic            set_en;
  logic            err_hit;
  logic [NREG-1:0] next_busy;
  logic [CW-1:0]   next_cnt;

  // Next busy vector: release committed writes, then apply the reservation.
  always_comb begin
    set_en    = resv_valid && (resv_num != '0) && !halted;
    next_busy = busy & ~clr;
    if (set_en) next_busy[resv_num] = 1'b1;
    next_busy[0] = 1'b0;
    err_hit  = set_en && busy[resv_num] && !clr[resv_num];
    next_cnt = '0;
    for (int i = 0; i < NREG; i++) next_cnt = next_cnt + CW'(next_busy[i]);
  end

  // Busy bits, their population count and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      busy        <= '0;
      pending_cnt <= '0;
      sb_err      <= 1'b0;
    end else begin
      busy        <= next_busy;
      pending_cnt <= next_cnt;
      if (err_hit) sb_err <= 1'b1;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with integrated scoreboard.
// Register 0 is hardwired to zero; the highest-numbered write port wins a
// same-index conflict. Optional macro REGFILE_BYPASS_EN enables
// write-first forwarding of same-cycle writes onto the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input logic         clk,
  input logic         rst_b,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NWR-1:0]  wr_ok;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy;
  logic [AW:0]     pending_cnt;
  logic            sb_err;

  // Qualify write ports and collect the registers they release.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NWR; i++) begin
      wr_ok[i] = bus.rd_we[i] && (bus.rd_num[i] != '0) && !bus.halted;
      if (wr_ok[i]) clr_vec[bus.rd_num[i]] = 1'b1;
    end
  end

  // Data array; later ports overwrite earlier ones so the highest port wins.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (wr_ok[i]) regs[bus.rd_num[i]] <= bus.rd_data[i];
    end
  end

  regfile_scoreboard #(.NREG(NREG)) u_sb (
    .clk        (clk),
    .rst_b      (rst_b),
    .halted     (bus.halted),
    .clr        (clr_vec),
    .resv_valid (bus.resv_valid),
    .resv_num   (bus.resv_num),
    .busy       (busy),
    .pending_cnt(pending_cnt),
    .sb_err     (sb_err)
  );

  assign bus.pending_cnt = pending_cnt;
  assign bus.sb_err      = sb_err;

  // Read ports: stored value and busy bit, optionally forwarded, index 0 forced to zero.
  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      bus.rs_data[j] = regs[bus.rs_num[j]];
      bus.rs_busy[j] = busy[bus.rs_num[j]];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NWR; i++) begin
        if (wr_ok[i] && (bus.rd_num[i] == bus.rs_num[j])) begin
          bus.rs_data[j] = bus.rd_data[i];
          bus.rs_busy[j] = bus.resv_valid && !bus.halted &&
                           (bus.resv_num == bus.rs_num[j]);
        end
      end
`endif
      if (bus.rs_num[j] == '0) begin
        bus.rs_data[j] = '0;
        bus.rs_busy[j] = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table plus directed sequences
// for conflicts, sticky error, halt, reset and forwarding.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_b;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) bus ();

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wn0;
    logic [31:0] wd0;
    logic [4:0]  wn1;
    logic [31:0] wd1;
    logic        resv;
    logic [4:0]  rn;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ebusy;
    logic [5:0]  ecnt;
    logic        eerr;
  } vec_t;

  vec_t vecs [12];

  task automatic clockStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    bus.rd_we      = 2'b00;
    bus.rd_num[0]  = 5'd0;
    bus.rd_num[1]  = 5'd0;
    bus.rd_data[0] = 32'h0;
    bus.rd_data[1] = 32'h0;
    bus.resv_valid = 1'b0;
    bus.resv_num   = 5'd0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.rd_we      = v.we;
    bus.rd_num[0]  = v.wn0;
    bus.rd_data[0] = v.wd0;
    bus.rd_num[1]  = v.wn1;
    bus.rd_data[1] = v.wd1;
    bus.resv_valid = v.resv;
    bus.resv_num   = v.rn;
    clockStep();
    clearInputs();
    bus.rs_num[0] = v.rs0;
    bus.rs_num[1] = v.rs1;
    #1;
  endtask

  task automatic reserve(input logic [4:0] r);
    bus.resv_valid = 1'b1;
    bus.resv_num   = r;
    clockStep();
    clearInputs();
  endtask

  task automatic doReset();
    rst_b = 1'b1;
    clockStep();
    rst_b = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{2'b11, 5'd5,  32'hDEADBEEF, 5'd5,  32'h12345678, 1'b0, 5'd0,  5'd5,  5'd0,  32'h12345678, 32'h0,        2'b00, 6'd0, 1'b0};
    vecs[1]  = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'h12345678, 2'b00, 6'd0, 1'b0};
    vecs[2]  = '{2'b11, 5'd1,  32'h11,       5'd2,  32'h22,       1'b0, 5'd0,  5'd1,  5'd2,  32'h11,       32'h22,       2'b00, 6'd0, 1'b0};
    vecs[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd1,  32'h0,        32'h11,       2'b01, 6'd1, 1'b0};
    vecs[4]  = '{2'b10, 5'd0,  32'h0,        5'd7,  32'h55,       1'b0, 5'd0,  5'd7,  5'd7,  32'h55,       32'h55,       2'b00, 6'd0, 1'b0};
    vecs[5]  = '{2'b01, 5'd7,  32'h77,       5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd7,  32'h77,       32'h77,       2'b11, 6'd1, 1'b0};
    vecs[6]  = '{2'b01, 5'd7,  32'h99,       5'd0,  32'h0,        1'b1, 5'd8,  5'd7,  5'd8,  32'h99,       32'h0,        2'b10, 6'd1, 1'b0};
    vecs[7]  = '{2'b11, 5'd8,  32'hAA,       5'd8,  32'hBB,       1'b0, 5'd0,  5'd8,  5'd7,  32'hBB,       32'h99,       2'b00, 6'd0, 1'b0};
    vecs[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0, 1'b0};
    vecs[9]  = '{2'b11, 5'd31, 32'hCAFEF00D, 5'd30, 32'h0BADF00D, 1'b1, 5'd31, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0BADF00D, 2'b01, 6'd1, 1'b0};
    vecs[10] = '{2'b01, 5'd31, 32'h1,        5'd0,  32'h0,        1'b1, 5'd31, 5'd31, 5'd31, 32'h1,        32'h1,        2'b11, 6'd1, 1'b0};
    vecs[11] = '{2'b10, 5'd6,  32'hBAD,      5'd31, 32'h2,        1'b0, 5'd0,  5'd31, 5'd6,  32'h2,        32'h0,        2'b00, 6'd0, 1'b0};

    clearInputs();
    bus.halted    = 1'b0;
    bus.rs_num[0] = 5'd0;
    bus.rs_num[1] = 5'd0;
    rst_b = 1'b1;
    clockStep();
    clockStep();
    rst_b = 1'b0;

    // Reset state on every index, both ports.
    for (int i = 0; i < 32; i++) begin
      bus.rs_num[0] = 5'(i);
      bus.rs_num[1] = 5'(31 - i);
      #1;
      checkOutput($sformatf("reset data0 r%0d", i), bus.rs_data[0], 32'h0);
      checkOutput($sformatf("reset data1 r%0d", 31 - i), bus.rs_data[1], 32'h0);
      checkOutput($sformatf("reset busy r%0d", i), 32'(bus.rs_busy), 32'h0);
    end
    checkOutput("reset pending_cnt", 32'(bus.pending_cnt), 32'h0);
    checkOutput("reset sb_err", 32'(bus.sb_err), 32'h0);

    // Table-driven vectors.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("v%0d rs_data0", k), bus.rs_data[0], vecs[k].e0);
      checkOutput($sformatf("v%0d rs_data1", k), bus.rs_data[1], vecs[k].e1);
      checkOutput($sformatf("v%0d rs_busy", k), 32'(bus.rs_busy), 32'(vecs[k].ebusy));
      checkOutput($sformatf("v%0d pending_cnt", k), 32'(bus.pending_cnt), 32'(vecs[k].ecnt));
      checkOutput($sformatf("v%0d sb_err", k), 32'(bus.sb_err), 32'(vecs[k].eerr));
    end

    // Double reservation of r3 sets the sticky error.
    bus.rs_num[0] = 5'd3;
    reserve(5'd3);
    #1;
    checkOutput("sb first resv err", 32'(bus.sb_err), 32'h0);
    checkOutput("sb first resv cnt", 32'(bus.pending_cnt), 32'h1);
    reserve(5'd3);
    #1;
    checkOutput("sb second resv err", 32'(bus.sb_err), 32'h1);
    checkOutput("sb second resv cnt", 32'(bus.pending_cnt), 32'h1);
    checkOutput("sb second resv busy", 32'(bus.rs_busy[0]), 32'h1);
    clockStep();
    clockStep();
    checkOutput("sb err sticky", 32'(bus.sb_err), 32'h1);

    // Halted: writes and reservations are ignored, state stays observable.
    bus.rd_we = 2'b01; bus.rd_num[0] = 5'd4; bus.rd_data[0] = 32'h40;
    clockStep();
    clearInputs();
    bus.halted = 1'b1;
    bus.rd_we = 2'b01; bus.rd_num[0] = 5'd4; bus.rd_data[0] = 32'h44;
    bus.resv_valid = 1'b1; bus.resv_num = 5'd9;
    bus.rs_num[0] = 5'd4; bus.rs_num[1] = 5'd9;
    #1;
    checkOutput("halt no forward r4", bus.rs_data[0], 32'h40);
    clockStep();
    clearInputs();
    checkOutput("halt r4 kept", bus.rs_data[0], 32'h40);
    checkOutput("halt r9 not busy", 32'(bus.rs_busy[1]), 32'h0);
    checkOutput("halt cnt kept", 32'(bus.pending_cnt), 32'h1);
    checkOutput("halt err kept", 32'(bus.sb_err), 32'h1);
    bus.halted = 1'b0;

    // Reset overrides a same-cycle write and reservation.
    bus.rd_we = 2'b01; bus.rd_num[0] = 5'd4; bus.rd_data[0] = 32'hFFFF;
    bus.resv_valid = 1'b1; bus.resv_num = 5'd12;
    bus.rs_num[1] = 5'd3;
    doReset();
    clearInputs();
    #1;
    checkOutput("rst r4 cleared", bus.rs_data[0], 32'h0);
    checkOutput("rst busy cleared", 32'(bus.rs_busy), 32'h0);
    checkOutput("rst cnt cleared", 32'(bus.pending_cnt), 32'h0);
    checkOutput("rst err cleared", 32'(bus.sb_err), 32'h0);

    // Same-cycle read of a register being written.
    bus.rs_num[0] = 5'd10;
    bus.rd_we = 2'b10; bus.rd_num[1] = 5'd10; bus.rd_data[1] = 32'hA5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("byp same cycle data", bus.rs_data[0], 32'hA5A5);
`else
    checkOutput("byp same cycle data", bus.rs_data[0], 32'h0);
`endif
    clockStep();
    clearInputs();
    checkOutput("byp next cycle data", bus.rs_data[0], 32'hA5A5);

    reserve(5'd10);
    bus.rd_we = 2'b01; bus.rd_num[0] = 5'd10; bus.rd_data[0] = 32'h5A5A;
    bus.resv_valid = 1'b1; bus.resv_num = 5'd10;
    #1;
    checkOutput("byp resv+wr busy", 32'(bus.rs_busy[0]), 32'h1);
    clockStep();
    clearInputs();
    checkOutput("resv+wr busy kept", 32'(bus.rs_busy[0]), 32'h1);
    checkOutput("resv+wr no err", 32'(bus.sb_err), 32'h0);
    checkOutput("resv+wr data", bus.rs_data[0], 32'h5A5A);
    bus.rd_we = 2'b01; bus.rd_num[0] = 5'd10; bus.rd_data[0] = 32'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("byp wr busy", 32'(bus.rs_busy[0]), 32'h0);
    checkOutput("byp wr data", bus.rs_data[0], 32'h1234);
`else
    checkOutput("byp wr busy", 32'(bus.rs_busy[0]), 32'h1);
    checkOutput("byp wr data", bus.rs_data[0], 32'h5A5A);
`endif
    clockStep();
    clearInputs();
    checkOutput("wr release busy", 32'(bus.rs_busy[0]), 32'h0);

    // Reserve every register: count saturates at NREG-1.
    doReset();
    for (int r = 1; r < 32; r++) reserve(5'(r));
    checkOutput("all busy cnt", 32'(bus.pending_cnt), 32'd31);
    checkOutput("all busy err", 32'(bus.sb_err), 32'h0);
    reserve(5'd0);
    checkOutput("resv r0 cnt", 32'(bus.pending_cnt), 32'd31);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
